// File: rtl/tlc_demand_scheduler_pkg.sv
// Shared definitions for the traffic-light controller blocks:
// state encodings, one-hot lamp codes {RED,YELLOW,GREEN} and road directions.
package tlc_demand_scheduler_pkg;

  localparam logic [2:0] ST_ALLRED    = 3'd0;
  localparam logic [2:0] ST_NS_GREEN  = 3'd1;
  localparam logic [2:0] ST_NS_YELLOW = 3'd2;
  localparam logic [2:0] ST_EW_GREEN  = 3'd3;
  localparam logic [2:0] ST_EW_YELLOW = 3'd4;
  localparam logic [2:0] ST_WALK      = 3'd5;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Lamp shown by one road in a given state; anything not owned by that road is red.
  function automatic logic [2:0] road_lamp(input logic [2:0] st, input logic dir);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    if (dir == DIR_NS) begin
      if (st == ST_NS_GREEN)  lamp = LAMP_GREEN;
      if (st == ST_NS_YELLOW) lamp = LAMP_YELLOW;
    end else begin
      if (st == ST_EW_GREEN)  lamp = LAMP_GREEN;
      if (st == ST_EW_YELLOW) lamp = LAMP_YELLOW;
    end
    return lamp;
  endfunction

endpackage

// File: rtl/tlc_demand_scheduler_timer.sv
// Phase timer: counts cycles spent in the current phase, cleared on every
// phase change and saturating at all-ones so a resting green never wraps.
module tlc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (count != {CNT_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_demand_scheduler.sv
// Demand-actuated phase scheduler for a two-road intersection with a pedestrian
// crossing. Handshake-free: sensors are levels, ped_req may be a single-cycle pulse.
module tlc_demand_scheduler
  import tlc_demand_scheduler_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ew_req,
  input  logic ns_req,
  input  logic ped_req,
  output logic EW_Red,
  output logic EW_Yellow,
  output logic EW_Green,
  output logic NS_Red,
  output logic NS_Yellow,
  output logic NS_Green,
  output logic walk,
  output logic ped_pend
);

  localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] timer;
  logic             next_dir;
  logic             ew_pend;
  logic             ns_pend;
  logic             ped_pend_q;
  logic             changing;
  logic [2:0]       dir_green;

  assign changing  = (state_next != state);
  assign dir_green = (next_dir == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;

  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (changing),
    .count (timer)
  );

  // A green yields only after its minimum, only when someone else is waiting,
  // and only once its own road is empty or the maximum has run out.
  always_comb begin
    state_next = state;
    case (state)
      ST_ALLRED: begin
        if (timer == ALLRED_END) state_next = ped_pend_q ? ST_WALK : dir_green;
      end
      ST_NS_GREEN: begin
        if (timer >= GMIN_END && (ew_pend || ped_pend_q) && (!ns_req || timer >= GMAX_END))
          state_next = ST_NS_YELLOW;
      end
      ST_NS_YELLOW: begin
        if (timer == YELLOW_END) state_next = ST_ALLRED;
      end
      ST_EW_GREEN: begin
        if (timer >= GMIN_END && (ns_pend || ped_pend_q) && (!ew_req || timer >= GMAX_END))
          state_next = ST_EW_YELLOW;
      end
      ST_EW_YELLOW: begin
        if (timer == YELLOW_END) state_next = ST_ALLRED;
      end
      ST_WALK: begin
        if (timer == WALK_END) state_next = dir_green;
      end
      default: state_next = ST_ALLRED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_ALLRED;
      next_dir <= DIR_NS;
    end else begin
      state <= state_next;
      if (state == ST_NS_YELLOW && state_next == ST_ALLRED) next_dir <= DIR_EW;
      if (state == ST_EW_YELLOW && state_next == ST_ALLRED) next_dir <= DIR_NS;
    end
  end

  // Entering the served state clears a latch even if the request is still present.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ew_pend    <= 1'b0;
      ns_pend    <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      if (changing && state_next == ST_EW_GREEN) ew_pend <= 1'b0;
      else if (ew_req && state != ST_EW_GREEN)   ew_pend <= 1'b1;

      if (changing && state_next == ST_NS_GREEN) ns_pend <= 1'b0;
      else if (ns_req && state != ST_NS_GREEN)   ns_pend <= 1'b1;

      if (changing && state_next == ST_WALK) ped_pend_q <= 1'b0;
      else if (ped_req)                      ped_pend_q <= 1'b1;
    end
  end

  assign {EW_Red, EW_Yellow, EW_Green} = road_lamp(state, DIR_EW);
  assign {NS_Red, NS_Yellow, NS_Green} = road_lamp(state, DIR_NS);
  assign walk     = (state == ST_WALK);
  assign ped_pend = ped_pend_q;

endmodule
